// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, sent LSB-first as start, data, optional parity and stop,
// with bit timing taken from the shared 16x baud tick.
module uart_tx #(
    parameter int data_bits      = 8,
    parameter int stop_bit_ticks = 16,
    parameter int parity_mode    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx_ready,
    output logic       tx_done_tick,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(stop_bit_ticks - 1);
    localparam logic [2:0] N_LAST    = 3'(data_bits - 1);

    state_t     state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       p_q, p_d;
    logic       tx_q, tx_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    b_d     = data_in;
                    s_d     = '0;
                    p_d     = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = (parity_mode != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is derived from the next state so each bit appears one clock after its boundary.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = (parity_mode == 2) ? p_d : ~p_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_ready     = (state_q == IDLE);
    assign tx_done_tick = (state_q == STOP) && s_tick && (s_q == STOP_LAST);
    assign tx           = tx_q;

endmodule
